// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine change dispenser.
// Coin values, controller state encoding and the one-hot coin select.
package vend_pkg;

    localparam int AMT_W = 9;
    localparam int CNT_W = 5;

    localparam logic [AMT_W-1:0] VAL_Q = 9'd25;
    localparam logic [AMT_W-1:0] VAL_D = 9'd10;
    localparam logic [AMT_W-1:0] VAL_N = 9'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        REQ    = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Bit order matches the eject lines and the jam flags: {q,d,n}.
    typedef enum logic [2:0] {
        SEL_NONE = 3'b000,
        SEL_N    = 3'b001,
        SEL_D    = 3'b010,
        SEL_Q    = 3'b100
    } coin_sel_t;

    // Largest coin that fits the remaining amount and whose hopper is usable.
    function automatic coin_sel_t pick_coin(input logic [AMT_W-1:0] remaining,
                                            input logic [2:0]       avail);
        coin_sel_t pick;
        pick = SEL_NONE;
        if (avail[2] && remaining >= VAL_Q)
            pick = SEL_Q;
        else if (avail[1] && remaining >= VAL_D)
            pick = SEL_D;
        else if (avail[0] && remaining >= VAL_N)
            pick = SEL_N;
        return pick;
    endfunction

    function automatic logic [AMT_W-1:0] coin_value(input coin_sel_t sel);
        logic [AMT_W-1:0] val;
        case (sel)
            SEL_Q:   val = VAL_Q;
            SEL_D:   val = VAL_D;
            SEL_N:   val = VAL_N;
            default: val = '0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/coin_hopper_ctr.sv
// Per-denomination hopper bookkeeping: stock, dispensed count, sticky jam
// flag and the acknowledge timeout counter for one coin type.
module coin_hopper_ctr
    import vend_pkg::*;
#(
    parameter logic [CNT_W-1:0] INIT        = 5'd20,
    parameter int               ACK_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill_stock,
    input  logic             req,
    input  logic             ack,
    output logic [CNT_W-1:0] stock,
    output logic [CNT_W-1:0] count,
    output logic             jam,
    output logic             timeout
);

    localparam int               TMR_W    = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    logic [TMR_W-1:0] timer;

    // Fires on the last cycle of the wait window; an ack in that cycle still wins.
    assign timeout = req && !ack && (timer == TMR_LAST);

    // NOTE: rst is absent from the sensitivity list, so reset takes effect only on a clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stock <= INIT;
            count <= '0;
            jam   <= 1'b0;
            timer <= '0;
        end else begin
            if (refill) begin
                stock <= refill_stock;
                jam   <= 1'b0;
            end
            if (clear)
                count <= '0;
            if (req) begin
                if (ack) begin
                    stock <= stock - CNT_W'(1);
                    count <= count + CNT_W'(1);
                    timer <= '0;
                end else if (timeout) begin
                    jam   <= 1'b1;
                    timer <= '0;
                end else begin
                    timer <= timer + TMR_W'(1);
                end
            end else begin
                timer <= '0;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: pays an owed amount out of quarter, dime and
// nickel hoppers one coin at a time over an eject/ack handshake.
module change_dispenser
    import vend_pkg::*;
#(
    parameter logic [CNT_W-1:0] Q_INIT      = 5'd20,
    parameter logic [CNT_W-1:0] D_INIT      = 5'd20,
    parameter logic [CNT_W-1:0] N_INIT      = 5'd20,
    parameter int               ACK_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             abort,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill_q,
    input  logic [CNT_W-1:0] refill_d,
    input  logic [CNT_W-1:0] refill_n,
    output logic             eject_q,
    output logic             eject_d,
    output logic             eject_n,
    input  logic             hopper_ack,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] quart,
    output logic [CNT_W-1:0] dim,
    output logic [CNT_W-1:0] nick,
    output logic [AMT_W-1:0] shortfall,
    output logic [2:0]       jam
);

    state_t           state, next_state;
    coin_sel_t        sel, pick;
    logic [AMT_W-1:0] remaining;
    logic             abort_q;
    logic             start_go, refill_go;
    logic             stop_now;
    logic [2:0]       avail;
    logic             to_q, to_d, to_n;
    logic [CNT_W-1:0] stock_q, stock_d, stock_n;

    // Refill has priority over start when both arrive in the same idle cycle.
    assign refill_go = (state == IDLE) && refill;
    assign start_go  = (state == IDLE) && start && !refill;

    assign avail = {(stock_q != '0) && !jam[2],
                    (stock_d != '0) && !jam[1],
                    (stock_n != '0) && !jam[0]};
    assign pick     = pick_coin(remaining, avail);
    assign stop_now = abort_q || abort;

    assign eject_q = (state == REQ) && (sel == SEL_Q);
    assign eject_d = (state == REQ) && (sel == SEL_D);
    assign eject_n = (state == REQ) && (sel == SEL_N);
    assign busy    = (state != IDLE);
    assign done    = (state == FINISH);

    coin_hopper_ctr #(.INIT(Q_INIT), .ACK_TIMEOUT(ACK_TIMEOUT)) u_hopper_q (
        .clk          (clk),
        .rst          (rst),
        .clear        (start_go),
        .refill       (refill_go),
        .refill_stock (refill_q),
        .req          (eject_q),
        .ack          (hopper_ack),
        .stock        (stock_q),
        .count        (quart),
        .jam          (jam[2]),
        .timeout      (to_q)
    );

    coin_hopper_ctr #(.INIT(D_INIT), .ACK_TIMEOUT(ACK_TIMEOUT)) u_hopper_d (
        .clk          (clk),
        .rst          (rst),
        .clear        (start_go),
        .refill       (refill_go),
        .refill_stock (refill_d),
        .req          (eject_d),
        .ack          (hopper_ack),
        .stock        (stock_d),
        .count        (dim),
        .jam          (jam[1]),
        .timeout      (to_d)
    );

    coin_hopper_ctr #(.INIT(N_INIT), .ACK_TIMEOUT(ACK_TIMEOUT)) u_hopper_n (
        .clk          (clk),
        .rst          (rst),
        .clear        (start_go),
        .refill       (refill_go),
        .refill_stock (refill_n),
        .req          (eject_n),
        .ack          (hopper_ack),
        .stock        (stock_n),
        .count        (nick),
        .jam          (jam[0]),
        .timeout      (to_n)
    );

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_go) next_state = SELECT;
            SELECT:  next_state = (stop_now || pick == SEL_NONE) ? FINISH : REQ;
            REQ:     if (hopper_ack || to_q || to_d || to_n) next_state = SELECT;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all state below is updated with <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sel       <= SEL_NONE;
            remaining <= '0;
            abort_q   <= 1'b0;
            shortfall <= '0;
        end else begin
            state <= next_state;

            if (state == IDLE)
                abort_q <= 1'b0;
            else if (abort)
                abort_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (start_go) begin
                        remaining <= change_amt;
                        shortfall <= '0;
                    end
                end
                SELECT: begin
                    sel <= pick;
                    // remaining is final here, so shortfall is already valid while done is high.
                    if (next_state == FINISH)
                        shortfall <= remaining;
                end
                REQ: begin
                    if (hopper_ack)
                        remaining <= remaining - coin_value(sel);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Payout end of the vending machine's coin path. The coin acceptor sums inserted money into a credit balance. This block takes the change amount the machine owes and drives the quarter, dime and nickel hoppers one coin at a time over a request/acknowledge handshake.
- It tracks hopper stock, reports per-denomination dispensed counts in the existing quart/dim/nick format, and reports any undispensable remainder.

Parameters:
- Q_INIT, 5'd20, quarter stock after reset.
- D_INIT, 5'd20, dime stock after reset.
- N_INIT, 5'd20, nickel stock after reset.
- ACK_TIMEOUT, 8, cycles to wait for hopper_ack before declaring that hopper jammed.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; latches change_amt; honoured only in IDLE.
- change_amt  in  9  cents owed, 0..511.
- abort  in  1  finish the in-flight coin, then stop.
- refill  in  1  load stock from refill_q/d/n; honoured only in IDLE; clears jam flags.
- refill_q, refill_d, refill_n  in  5 each  new stock values.
- eject_q, eject_d, eject_n  out  1 each  one-hot coin request; held high until hopper_ack.
- hopper_ack  in  1  hopper confirms one coin released.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse on completion.
- quart, dim, nick  out  5 each  coins dispensed for the current or last transaction.
- shortfall  out  9  cents not paid out; valid when done pulses and held until the next start.
- jam  out  3  sticky per-hopper jam flags, bits {q,d,n}.

Behaviour:
- Reset (rst==0 at an edge):
  - State IDLE. All eject lines, busy and done are 0.
  - quart, dim, nick, shortfall and jam are 0.
  - Stock is Q_INIT, D_INIT and N_INIT.
  - Reset mid-transaction drops the eject lines on the same edge; the remaining amount is lost.
- State IDLE:
  - start loads remaining<=change_amt, clears quart/dim/nick/shortfall, and goes to SELECT.
  - refill in the same cycle as start: refill wins and start is ignored.
- State SELECT (one cycle), picking the first coin that fits:
  - Quarter if remaining>=25, stock_q>0 and !jam[2].
  - Else dime if remaining>=10, stock_d>0 and !jam[1].
  - Else nickel if remaining>=5, stock_n>0 and !jam[0].
  - A coin selected -> REQ. None selected, or abort seen -> FINISH.
- State REQ:
  - The selected eject line is high and the timeout counter runs.
  - On hopper_ack: remaining-=value, stock-=1, count+=1, drop eject, -> SELECT. The eject line is therefore high for ack-latency+1 cycles.
  - Counter reaching ACK_TIMEOUT without ack: set that jam bit, drop eject, -> SELECT, which retries with a lower coin.
  - hopper_ack outside REQ is ignored.
- State FINISH (one cycle): shortfall<=remaining, done=1, -> IDLE.
- Latency: a zero-amount start gives done 2 cycles after start. Each coin adds 2 cycles plus the hopper ack latency.
- abort is latched in any non-IDLE state. It never cuts an eject line mid-handshake.
- Arithmetic:
  - remaining is 9-bit unsigned and never underflows, because a coin is selected only when remaining >= its value.
  - Amounts that are not a multiple of 5 leave a 1..4 cent shortfall.
  - Counts cannot exceed 31 because stock is 5-bit.
- start while busy is ignored. refill while busy is ignored.

Decomposition:
- Shared package vend_pkg:
  - Coin values VAL_Q=25, VAL_D=10, VAL_N=5.
  - State encoding IDLE, SELECT, REQ, FINISH.
  - Coin-select one-hot encoding.
- One sub-module, coin_hopper_ctr, instantiated three times. Each instance holds stock, count, jam bit and the timeout counter for one denomination.

Test Plan:
- Reset, then start with change_amt=100 and ack 1 cycle after each eject -> 4 eject_q handshakes; done with quart=4, dim=0, nick=0, shortfall=0.
- refill q=1,d=1,n=31, then change_amt=45 -> quart=1, dim=1, nick=2, shortfall=0; quarter stock ends at 0.
- Stock q=0,d=0,n=2 and change_amt=23 -> nick=2, shortfall=13, done pulses once.
- Quarter hopper never acks, change_amt=25, ACK_TIMEOUT=8 -> eject_q high 8 cycles, jam=3'b100, then dim=2 and nick=1.
- change_amt=200, abort raised during the 2nd quarter's REQ -> that coin completes; quart=2, shortfall=150.
- Reset asserted during REQ -> eject lines 0 on the reset edge, stock back to INIT values; start held while busy is ignored.
